// File: rtl/dram_gate_pkg.sv
// Shared types and constants for the DRAM admission gate.
package dram_gate_pkg;

  typedef enum logic [1:0] {StInit, StOpen, StDrain, StClosed} gate_state_e;
  typedef enum logic [1:0] {ErrIdle, ErrData, ErrResp} err_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } gate_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } gate_w_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } gate_b_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } gate_r_t;

  typedef struct packed {
    gate_ax_t aw;
    logic     aw_valid;
    gate_w_t  w;
    logic     w_valid;
    logic     b_ready;
    gate_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } gate_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    gate_b_t b;
    logic    r_valid;
    gate_r_t r;
  } gate_rsp_t;

endpackage

// File: rtl/dram_gate_cnt.sv
// Saturating up/down outstanding-transaction counter with full/empty flags.
module dram_gate_cnt #(
  parameter int unsigned  Max  = 8,
  localparam int unsigned CntW = $clog2(Max + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(Max);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign full_o  = (cnt_q == MaxCnt);
  assign empty_o = (cnt_q == '0);

  // A response with nothing outstanding means the downstream broke protocol.
  UnderflowA: assert property (@(posedge clk_i) disable iff (!rst_ni) !(dec_i && empty_o));

endmodule

// File: rtl/dram_axi_gate.sv
// AXI admission gate in front of the DRAM wrapper: holds traffic until calibration, limits
// outstanding transactions, drains on flush. DRAM_GATE_ERR_RESP_EN enables local DECERR replies.
module dram_axi_gate
  import dram_gate_pkg::*;
#(
  parameter int unsigned  MaxTxns   = 8,
  parameter type          axi_req_t = dram_gate_pkg::gate_req_t,
  parameter type          axi_rsp_t = dram_gate_pkg::gate_rsp_t,
  localparam int unsigned CntW      = $clog2(MaxTxns + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            calib_done_i,
  input  logic            flush_req_i,
  output logic            flush_ack_o,
  output logic            open_o,
  output logic [CntW-1:0] wr_pending_o,
  output logic [CntW-1:0] rd_pending_o,
  input  axi_req_t        slv_req_i,
  output axi_rsp_t        slv_rsp_o,
  output axi_req_t        mst_req_o,
  input  axi_rsp_t        mst_rsp_i
);

  logic calib_meta_q, calib_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      calib_meta_q <= 1'b0;
      calib_q      <= 1'b0;
    end else begin
      calib_meta_q <= calib_done_i;
      calib_q      <= calib_meta_q;
    end
  end

  gate_state_e     state_d, state_q;
  logic            wr_full, wr_empty, rd_full, rd_empty;
  logic [CntW-1:0] wr_cnt, rd_cnt;
  logic            aw_hs, ar_hs, b_hs, r_last_hs, drained;
  logic            aw_pass, ar_pass;
  axi_req_t        mst_req;
  axi_rsp_t        slv_rsp;

  logic               err_busy;
  logic               err_aw_ready, err_ar_ready, err_w_take, err_b_valid, err_r_valid;
  logic               err_r_last;
  logic [IdWidth-1:0] err_bid, err_rid;

  assign aw_pass = (state_q == StOpen) && !wr_full;
  assign ar_pass = (state_q == StOpen) && !rd_full;

  always_comb begin
    mst_req = slv_req_i;
    slv_rsp = mst_rsp_i;
    mst_req.aw_valid = slv_req_i.aw_valid & aw_pass;
    mst_req.ar_valid = slv_req_i.ar_valid & ar_pass;
    slv_rsp.aw_ready = (mst_rsp_i.aw_ready & aw_pass) | err_aw_ready;
    slv_rsp.ar_ready = (mst_rsp_i.ar_ready & ar_pass) | err_ar_ready;
    if (err_w_take) begin
      mst_req.w_valid = 1'b0;
      slv_rsp.w_ready = 1'b1;
    end
    if (err_b_valid) begin
      mst_req.b_ready = 1'b0;
      slv_rsp.b_valid = 1'b1;
      slv_rsp.b.id    = err_bid;
      slv_rsp.b.resp  = RespDecerr;
    end
    if (err_r_valid) begin
      mst_req.r_ready = 1'b0;
      slv_rsp.r_valid = 1'b1;
      slv_rsp.r.id    = err_rid;
      slv_rsp.r.data  = '0;
      slv_rsp.r.resp  = RespDecerr;
      slv_rsp.r.last  = err_r_last;
    end
    // Keep every handshake line quiet while reset is asserted.
    if (!rst_ni) begin
      mst_req.aw_valid = 1'b0;
      mst_req.w_valid  = 1'b0;
      mst_req.b_ready  = 1'b0;
      mst_req.ar_valid = 1'b0;
      mst_req.r_ready  = 1'b0;
      slv_rsp.aw_ready = 1'b0;
      slv_rsp.w_ready  = 1'b0;
      slv_rsp.b_valid  = 1'b0;
      slv_rsp.ar_ready = 1'b0;
      slv_rsp.r_valid  = 1'b0;
    end
  end

  assign mst_req_o = mst_req;
  assign slv_rsp_o = slv_rsp;

  assign aw_hs     = mst_req.aw_valid & mst_rsp_i.aw_ready;
  assign ar_hs     = mst_req.ar_valid & mst_rsp_i.ar_ready;
  assign b_hs      = mst_rsp_i.b_valid & mst_req.b_ready;
  assign r_last_hs = mst_rsp_i.r_valid & mst_req.r_ready & mst_rsp_i.r.last;

  dram_gate_cnt #(
    .Max(MaxTxns)
  ) u_wr_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (aw_hs),
    .dec_i  (b_hs),
    .count_o(wr_cnt),
    .full_o (wr_full),
    .empty_o(wr_empty)
  );

  dram_gate_cnt #(
    .Max(MaxTxns)
  ) u_rd_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ar_hs),
    .dec_i  (r_last_hs),
    .count_o(rd_cnt),
    .full_o (rd_full),
    .empty_o(rd_empty)
  );

  // No new requests are admitted in DRAIN, so the final response retires the last count
  // and CLOSED can be entered on that same edge.
  assign drained = (wr_empty | ((wr_cnt == CntW'(1)) & b_hs)) &
                   (rd_empty | ((rd_cnt == CntW'(1)) & r_last_hs));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   if (calib_q && !flush_req_i && !err_busy) state_d = StOpen;
      StOpen:   if (flush_req_i || !calib_q) state_d = StDrain;
      StDrain:  if (drained) state_d = StClosed;
      StClosed: if (calib_q && !flush_req_i && !err_busy) state_d = StOpen;
      default:  state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  assign open_o       = (state_q == StOpen);
  assign flush_ack_o  = (state_q == StClosed);
  assign wr_pending_o = wr_cnt;
  assign rd_pending_o = rd_cnt;

`ifdef DRAM_GATE_ERR_RESP_EN
  err_state_e         werr_d, werr_q, rerr_d, rerr_q;
  logic [IdWidth-1:0] wid_d, wid_q, rid_d, rid_q;
  logic [7:0]         rbeats_d, rbeats_q;
  logic               local_open, err_aw_hs, err_ar_hs;

  assign local_open   = (state_q == StInit) || (state_q == StClosed);
  assign err_aw_ready = local_open && (werr_q == ErrIdle);
  assign err_ar_ready = local_open && (rerr_q == ErrIdle);
  assign err_aw_hs    = err_aw_ready && slv_req_i.aw_valid;
  assign err_ar_hs    = err_ar_ready && slv_req_i.ar_valid;
  assign err_w_take   = (werr_q == ErrData);
  assign err_b_valid  = (werr_q == ErrResp);
  assign err_r_valid  = (rerr_q == ErrData);
  assign err_r_last   = (rbeats_q == '0);
  assign err_bid      = wid_q;
  assign err_rid      = rid_q;
  // Includes the accepting cycle so the gate cannot reopen under a just-accepted request.
  assign err_busy     = err_aw_hs | err_ar_hs | (werr_q != ErrIdle) | (rerr_q != ErrIdle);

  always_comb begin
    werr_d = werr_q;
    wid_d  = wid_q;
    unique case (werr_q)
      ErrIdle: begin
        if (err_aw_hs) begin
          werr_d = ErrData;
          wid_d  = slv_req_i.aw.id;
        end
      end
      ErrData: if (slv_req_i.w_valid && slv_req_i.w.last) werr_d = ErrResp;
      ErrResp: if (slv_req_i.b_ready) werr_d = ErrIdle;
      default: werr_d = ErrIdle;
    endcase
  end

  always_comb begin
    rerr_d   = rerr_q;
    rid_d    = rid_q;
    rbeats_d = rbeats_q;
    unique case (rerr_q)
      ErrIdle: begin
        if (err_ar_hs) begin
          rerr_d   = ErrData;
          rid_d    = slv_req_i.ar.id;
          rbeats_d = slv_req_i.ar.len;
        end
      end
      ErrData: begin
        if (slv_req_i.r_ready) begin
          if (err_r_last) rerr_d = ErrIdle;
          else            rbeats_d = rbeats_q - 1'b1;
        end
      end
      default: rerr_d = ErrIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      werr_q   <= ErrIdle;
      rerr_q   <= ErrIdle;
      wid_q    <= '0;
      rid_q    <= '0;
      rbeats_q <= '0;
    end else begin
      werr_q   <= werr_d;
      rerr_q   <= rerr_d;
      wid_q    <= wid_d;
      rid_q    <= rid_d;
      rbeats_q <= rbeats_d;
    end
  end
`else
  assign err_busy     = 1'b0;
  assign err_aw_ready = 1'b0;
  assign err_ar_ready = 1'b0;
  assign err_w_take   = 1'b0;
  assign err_b_valid  = 1'b0;
  assign err_r_valid  = 1'b0;
  assign err_r_last   = 1'b0;
  assign err_bid      = '0;
  assign err_rid      = '0;
`endif

endmodule

// File: tb/tb_dram_axi_gate.sv
// Directed bench for dram_axi_gate with MaxTxns=2; the downstream is a bench-driven mock.
module tb_dram_axi_gate;
  import dram_gate_pkg::*;

  logic       clk_i;
  logic       rst_ni;
  logic       calib_done_i;
  logic       flush_req_i;
  logic       flush_ack_o;
  logic       open_o;
  logic [1:0] wr_pending_o;
  logic [1:0] rd_pending_o;
  gate_req_t  slv_req;
  gate_rsp_t  slv_rsp;
  gate_req_t  mst_req;
  gate_rsp_t  mst_rsp;

  int   checks;
  int   errors;
  logic seen;

  dram_axi_gate #(
    .MaxTxns(2)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .calib_done_i(calib_done_i),
    .flush_req_i (flush_req_i),
    .flush_ack_o (flush_ack_o),
    .open_o      (open_o),
    .wr_pending_o(wr_pending_o),
    .rd_pending_o(rd_pending_o),
    .slv_req_i   (slv_req),
    .slv_rsp_o   (slv_rsp),
    .mst_req_o   (mst_req),
    .mst_rsp_i   (mst_rsp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    seen   = 1'b0;
    rst_ni = 1'b0;
    calib_done_i = 1'b0;
    flush_req_i  = 1'b0;
    slv_req = '0;
    mst_rsp = '0;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    slv_req.w_valid  = 1'b1;

    // Reset values and quiet handshake lines during reset.
    repeat (2) @(negedge clk_i);
    chk("rst_open", open_o, 0);
    chk("rst_flush_ack", flush_ack_o, 0);
    chk("rst_wr_pending", wr_pending_o, 0);
    chk("rst_rd_pending", rd_pending_o, 0);
    chk("rst_slv_w_ready", slv_rsp.w_ready, 0);
    chk("rst_mst_w_valid", mst_req.w_valid, 0);
    slv_req.w_valid = 1'b0;
    rst_ni = 1'b1;

    // Calibration gating.
`ifndef DRAM_GATE_ERR_RESP_EN
    slv_req.ar_valid = 1'b1;
`endif
    slv_req.ar.id  = 4'd5;
    slv_req.ar.len = 8'd3;
    repeat (100) begin
      @(negedge clk_i);
      if (mst_req.ar_valid || slv_rsp.ar_ready) seen = 1'b1;
    end
    chk("calib_stall", seen, 0);
    calib_done_i = 1'b1;
    @(negedge clk_i);
    chk("calib_edge1_ar", mst_req.ar_valid, 0);
    @(negedge clk_i);
    chk("calib_edge2_open", open_o, 0);
    @(negedge clk_i);
    chk("calib_edge3_open", open_o, 1);
`ifdef DRAM_GATE_ERR_RESP_EN
    slv_req.ar_valid = 1'b1;
    #1;
`endif
    chk("ar_fwd", mst_req.ar_valid, 1);
    chk("ar_fwd_id", mst_req.ar.id, 5);
    @(negedge clk_i);
    slv_req.ar_valid = 1'b0;
    chk("rd_pend_1", rd_pending_o, 1);
    slv_req.r_ready  = 1'b1;
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.id     = 4'd5;
    for (int i = 0; i < 4; i++) begin
      mst_rsp.r.last = (i == 3);
      mst_rsp.r.data = 64'h100 + 64'(i);
      #1;
      chk("r_pass_data", slv_rsp.r.data, 64'h100 + 64'(i));
      chk("r_pass_last", slv_rsp.r.last, (i == 3));
      if (i == 3) chk("rd_pend_before_last", rd_pending_o, 1);
      @(negedge clk_i);
    end
    mst_rsp.r_valid = 1'b0;
    mst_rsp.r.last  = 1'b0;
    chk("rd_pend_0", rd_pending_o, 0);

    // Outstanding-write limit.
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'd1;
    #1;
    chk("aw1_fwd", mst_req.aw_valid, 1);
    @(negedge clk_i);
    slv_req.aw.id = 4'd2;
    chk("wr_pend_1", wr_pending_o, 1);
    @(negedge clk_i);
    slv_req.aw.id = 4'd3;
    chk("wr_pend_2", wr_pending_o, 2);
    #1;
    chk("aw3_stall_mst", mst_req.aw_valid, 0);
    chk("aw3_stall_slv", slv_rsp.aw_ready, 0);
    slv_req.w_valid = 1'b1;
    slv_req.w.last  = 1'b1;
    #1;
    chk("w_pass_valid", mst_req.w_valid, 1);
    chk("w_pass_ready", slv_rsp.w_ready, 1);
    slv_req.w_valid  = 1'b0;
    slv_req.w.last   = 1'b0;
    mst_rsp.b_valid  = 1'b1;
    mst_rsp.b.id     = 4'd1;
    slv_req.b_ready  = 1'b1;
    #1;
    chk("full_dec_still_blocked", mst_req.aw_valid, 0);
    chk("b_pass_id", slv_rsp.b.id, 1);
    @(negedge clk_i);
    mst_rsp.b_valid = 1'b0;
    chk("wr_pend_after_b", wr_pending_o, 1);
    #1;
    chk("aw3_fwd", mst_req.aw_valid, 1);
    chk("aw3_id", mst_req.aw.id, 3);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    chk("wr_pend_2_again", wr_pending_o, 2);

    // Simultaneous B and AW at count 1.
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 4'd2;
    @(negedge clk_i);
    chk("wr_pend_1_again", wr_pending_o, 1);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'd4;
    mst_rsp.b.id     = 4'd3;
    #1;
    chk("aw4_fwd", mst_req.aw_valid, 1);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    chk("simul_pend", wr_pending_o, 1);
    mst_rsp.b.id = 4'd4;
    @(negedge clk_i);
    mst_rsp.b_valid = 1'b0;
    chk("wr_pend_0", wr_pending_o, 0);

    // Flush with two reads outstanding.
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd1;
    slv_req.ar.len   = 8'd0;
    @(negedge clk_i);
    slv_req.ar.id = 4'd2;
    @(negedge clk_i);
    slv_req.ar_valid = 1'b0;
    chk("rd_pend_2", rd_pending_o, 2);
    flush_req_i = 1'b1;
    @(negedge clk_i);
    chk("drain_open", open_o, 0);
    chk("drain_ack", flush_ack_o, 0);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd3;
    #1;
    chk("drain_ar_stall", mst_req.ar_valid, 0);
    chk("drain_ar_ready", slv_rsp.ar_ready, 0);
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.last   = 1'b1;
    mst_rsp.r.id     = 4'd1;
    @(negedge clk_i);
    chk("drain_rd_1", rd_pending_o, 1);
    chk("drain_ack_1", flush_ack_o, 0);
    mst_rsp.r.id = 4'd2;
    @(negedge clk_i);
    mst_rsp.r_valid = 1'b0;
    mst_rsp.r.last  = 1'b0;
    chk("flush_ack", flush_ack_o, 1);
    chk("rd_pend_0_flush", rd_pending_o, 0);

`ifndef DRAM_GATE_ERR_RESP_EN
    // CLOSED stalls a queued AW.
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'd7;
    repeat (3) @(negedge clk_i);
    chk("closed_aw_ready", slv_rsp.aw_ready, 0);
    chk("closed_aw_valid", mst_req.aw_valid, 0);
    chk("closed_ack_held", flush_ack_o, 1);
`else
    // Local DECERR read: len=1 gives two beats.
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd9;
    slv_req.ar.len   = 8'd1;
    #1;
    chk("err_ar_ready", slv_rsp.ar_ready, 1);
    chk("err_ar_mst", mst_req.ar_valid, 0);
    @(negedge clk_i);
    slv_req.ar_valid = 1'b0;
    chk("err_r1_valid", slv_rsp.r_valid, 1);
    chk("err_r1_resp", slv_rsp.r.resp, 3);
    chk("err_r1_data", slv_rsp.r.data, 0);
    chk("err_r1_last", slv_rsp.r.last, 0);
    chk("err_r1_id", slv_rsp.r.id, 9);
    @(negedge clk_i);
    chk("err_r2_valid", slv_rsp.r_valid, 1);
    chk("err_r2_last", slv_rsp.r.last, 1);
    @(negedge clk_i);
    chk("err_r_done", slv_rsp.r_valid, 0);
    // Local DECERR write with four W beats.
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'd4;
    #1;
    chk("err_aw_ready", slv_rsp.aw_ready, 1);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_req.w.last = (i == 3);
      #1;
      chk("err_w_ready", slv_rsp.w_ready, 1);
      chk("err_w_blocked", mst_req.w_valid, 0);
      @(negedge clk_i);
    end
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    chk("err_b_valid", slv_rsp.b_valid, 1);
    chk("err_b_id", slv_rsp.b.id, 4);
    chk("err_b_resp", slv_rsp.b.resp, 3);
    @(negedge clk_i);
    chk("err_b_done", slv_rsp.b_valid, 0);
`endif

    // Reopen and forward the queued AW.
    flush_req_i = 1'b0;
    @(negedge clk_i);
    chk("reopen", open_o, 1);
    chk("reopen_ack", flush_ack_o, 0);
`ifdef DRAM_GATE_ERR_RESP_EN
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'd7;
`endif
    #1;
    chk("queued_aw_fwd", mst_req.aw_valid, 1);
    chk("queued_aw_id", mst_req.aw.id, 7);
    @(negedge clk_i);
    slv_req.aw_valid = 1'b0;
    chk("wr_pend_reopen", wr_pending_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
